// File: rtl/enemy_wave_scheduler_pkg.sv
// Shared game package for the enemy wave scheduler.
// Holds slot count, screen edge, FSM encoding and a 10-bit popcount.
package enemy_wave_scheduler_pkg;

    localparam int NUM_SLOTS = 10;
    localparam int Y_EDGE    = 120;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 10; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/enemy_wave_scheduler_if.sv
// Game-control bus between the scheduler, collision logic and Y counters.
// master: drives start/hit/touch_edge; slave: drives the slot and score outputs.
interface enemy_wave_scheduler_if;
    logic       start;
    logic [9:0] hit;
    logic [9:0] touch_edge;
    logic [9:0] c_en;
    logic [9:0] des;
    logic       move_en;
    logic [1:0] flying_rate;
    logic [1:0] lives;
    logic [7:0] score;
    logic       game_over;

    modport master (
        output start, hit, touch_edge,
        input  c_en, des, move_en, flying_rate, lives, score, game_over
    );

    modport slave (
        input  start, hit, touch_edge,
        output c_en, des, move_en, flying_rate, lives, score, game_over
    );
endinterface

// File: rtl/enemy_wave_scheduler_slot_picker.sv
// Circular first-free search over the slot-busy vector, starting at i_ptr.
// Ports: i_busy (10), i_ptr (4) in; o_idx (4), o_found out.
module enemy_wave_scheduler_slot_picker
    import enemy_wave_scheduler_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] i_busy,
    input  logic [3:0]           i_ptr,
    output logic [3:0]           o_idx,
    output logic                 o_found
);

    logic [4:0] w_j;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_j = {1'b0, i_ptr} + 5'(k);
            if (w_j >= 5'(NUM_SLOTS)) begin
                w_j = w_j - 5'(NUM_SLOTS);
            end
            if (!o_found && !i_busy[w_j[3:0]]) begin
                o_idx   = w_j[3:0];
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Enemy wave scheduler: spawns planes, retires hits/escapes, tracks lives/score/level.
// Ports: clk, reset (sync, active-high); bus (slave) carries start/hit/touch_edge in
// and c_en/des/move_en/flying_rate/lives/score/game_over out, all registered.
module enemy_wave_scheduler
    import enemy_wave_scheduler_pkg::*;
#(
    parameter int SPAWN_CYCLES    = 50000000,
    parameter int KILLS_PER_LEVEL = 8,
    parameter int START_LIVES     = 3
)
(
    input  logic                  clk,
    input  logic                  reset,
    enemy_wave_scheduler_if.slave bus
);

    localparam int CW = $clog2(SPAWN_CYCLES + 1);
    localparam int KW = $clog2(KILLS_PER_LEVEL + NUM_SLOTS + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SPAWN_CYCLES - 1);

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [3:0]    r_ptr, w_ptr_n;
    logic [KW-1:0] r_kills, w_kills_n;
    logic [9:0]    r_c_en, w_c_en_n;
    logic [9:0]    r_des, w_des_n;
    logic          r_move_en, w_move_en_n;
    logic          r_game_over, w_go_n;
    logic [1:0]    r_rate, w_rate_n;
    logic [1:0]    r_lives, w_lives_n;
    logic [7:0]    r_score, w_score_n;

    logic [9:0]    w_hit_v, w_esc_v;
    logic [3:0]    w_nhit, w_nesc, w_pick;
    logic          w_found;
    logic [8:0]    w_score_sum;
    logic [KW-1:0] w_kill_sum;

    // A simultaneous hit and edge touch on one slot is scored as a hit.
    assign w_hit_v = bus.hit & r_c_en;
    assign w_esc_v = bus.touch_edge & ~bus.hit & r_c_en;
    assign w_nhit  = popcount10(w_hit_v);
    assign w_nesc  = popcount10(w_esc_v);

    // Search uses registered c_en, so a slot retired this cycle is not reused yet.
    enemy_wave_scheduler_slot_picker u_slot_picker (
        .i_busy  (r_c_en),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_ptr_n     = r_ptr;
        w_kills_n   = r_kills;
        w_c_en_n    = r_c_en;
        w_des_n     = r_des;
        w_move_en_n = r_move_en;
        w_go_n      = r_game_over;
        w_rate_n    = r_rate;
        w_lives_n   = r_lives;
        w_score_n   = r_score;
        w_score_sum = {1'b0, r_score} + 9'(w_nhit);
        w_kill_sum  = r_kills + KW'(w_nhit);
        unique case (r_state)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    w_state_n   = ST_RUN;
                    w_lives_n   = 2'(START_LIVES);
                    w_score_n   = '0;
                    w_kills_n   = '0;
                    w_rate_n    = '0;
                    w_c_en_n    = '0;
                    w_des_n     = '0;
                    w_cnt_n     = RELOAD;
                    w_ptr_n     = '0;
                    w_move_en_n = 1'b1;
                    w_go_n      = 1'b0;
                end
            end
            ST_RUN: begin
                w_move_en_n = 1'b1;
                w_des_n     = w_hit_v | w_esc_v;
                w_c_en_n    = r_c_en & ~(w_hit_v | w_esc_v);
                if (r_cnt == '0) begin
                    w_cnt_n = RELOAD;
                    if (w_found) begin
                        w_c_en_n[w_pick] = 1'b1;
                        w_ptr_n = (w_pick == 4'd9) ? 4'd0 : w_pick + 4'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt - CW'(1);
                end
                w_score_n = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
                if (w_kill_sum >= KW'(KILLS_PER_LEVEL)) begin
                    w_kills_n = w_kill_sum - KW'(KILLS_PER_LEVEL);
                    if (r_rate != 2'd3) begin
                        w_rate_n = r_rate + 2'd1;
                    end
                end else begin
                    w_kills_n = w_kill_sum;
                end
                if (w_nesc >= {2'b00, r_lives}) begin
                    w_lives_n = 2'd0;
                end else begin
                    w_lives_n = r_lives - w_nesc[1:0];
                end
                // Game ends on the same edge lives hit zero; hold every Y at 0.
                if (w_lives_n == 2'd0) begin
                    w_state_n   = ST_OVER;
                    w_c_en_n    = '0;
                    w_des_n     = 10'h3FF;
                    w_move_en_n = 1'b0;
                    w_go_n      = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= RELOAD;
            r_ptr       <= '0;
            r_kills     <= '0;
            r_c_en      <= '0;
            r_des       <= '0;
            r_move_en   <= 1'b0;
            r_game_over <= 1'b0;
            r_rate      <= '0;
            r_lives     <= 2'(START_LIVES);
            r_score     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_ptr       <= w_ptr_n;
            r_kills     <= w_kills_n;
            r_c_en      <= w_c_en_n;
            r_des       <= w_des_n;
            r_move_en   <= w_move_en_n;
            r_game_over <= w_go_n;
            r_rate      <= w_rate_n;
            r_lives     <= w_lives_n;
            r_score     <= w_score_n;
        end
    end

    assign bus.c_en        = r_c_en;
    assign bus.des         = r_des;
    assign bus.move_en     = r_move_en;
    assign bus.flying_rate = r_rate;
    assign bus.lives       = r_lives;
    assign bus.score       = r_score;
    assign bus.game_over   = r_game_over;

endmodule

// File: doc/enemy_wave_scheduler.md
# enemy_wave_scheduler

Game-level controller for the enemy-plane Y-coordinate datapath. Decides when and into which of the 10 enemy slots a plane spawns, drives the per-slot enable and destroy lines plus the shared move enable and flying rate, and retires planes on player hits or bottom-edge escapes. Also keeps lives, score and difficulty level, and sits between the collision logic and the Y-coordinate counter bank.

## Interface
Parameters:
- SPAWN_CYCLES, 50000000: spawn period in clk cycles (1 s at 50 MHz).
- KILLS_PER_LEVEL, 8: kills per difficulty step.
- START_LIVES, 3: lives loaded at game start, range 1..3.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- start  in  1  one-cycle pulse; starts a game from IDLE or OVER.
- hit  in  10  per-slot collision pulse (player shot hit plane i).
- touch_edge  in  10  per-slot level, high while plane i sits at Y = 120.
- c_en  out  10  per-slot plane active / Y-count enable.
- des  out  10  per-slot destroy; holds that slot's Y at 0.
- move_en  out  1  enables the shared move tick.
- flying_rate  out  2  speed select, 0 = slowest, 3 = fastest.
- lives  out  2  remaining lives.
- score  out  8  kill count, saturating at 255.
- game_over  out  1  high in OVER.

## Operation
- FSM states:
  - IDLE: entered at reset; waits for `start`.
  - RUN: normal play.
  - OVER: entered after lives reach 0; waits for `start`.
- IDLE/OVER + start -> RUN. Same edge: lives = START_LIVES, score = 0, kill counter = 0, flying_rate = 0, c_en = 0, des = 0, spawn counter = SPAWN_CYCLES-1, round-robin pointer = 0.
- RUN outputs:
  - move_en = 1.
  - Spawn counter decrements each cycle. At 0 it reloads and a spawn is attempted.
  - Spawn target: the first slot i with c_en[i] = 0, searched circularly from the pointer, using the registered c_en value.
  - On a spawn, c_en[i] is set and the pointer becomes (i+1) mod 10. If all slots are busy, the spawn is skipped and the pointer is unchanged.
- Retire rules, RUN only, slot i with c_en[i] = 1:
  - hit[i]: clear c_en[i], pulse des[i] for 1 cycle, increment score (saturating) and the kill counter.
  - touch_edge[i] and not hit[i]: clear c_en[i], pulse des[i] for 1 cycle, decrement lives (saturating at 0).
  - hit and touch_edge on the same slot in the same cycle: counts as a hit.
  - hit or touch_edge on an inactive slot: ignored.
- Multiple hits or escapes in one cycle: score += popcount(hits), lives -= popcount(escapes), each saturating.
- Difficulty: when the kill counter reaches KILLS_PER_LEVEL, it clears and flying_rate increments, saturating at 3.
- A slot freed in cycle N can be chosen for a spawn in N+1 at the earliest, never in N.
- If the next value of lives is 0: RUN -> OVER on the same edge.
- OVER outputs: c_en = 0, des = 10'h3FF (all Y values held at 0), move_en = 0, game_over = 1; score frozen.
- IDLE outputs: c_en = 0, des = 0, move_en = 0.

## Timing
- Reset values: state IDLE, c_en 0, des 0, move_en 0, flying_rate 0, lives START_LIVES, score 0, game_over 0, pointer 0.
- All outputs are registered.
- Reset asserted mid-game forces the reset values on the next edge; it overrides start, hit and touch_edge.
- First spawn: c_en is set SPAWN_CYCLES edges after the start edge. Later spawns follow every SPAWN_CYCLES cycles.
- Retire latency is 1 cycle. c_en falls and des rises on the same edge, so the counter sees enable = 0 with destroy = 1 and zeroes Y on the following edge.
- des pulses last exactly 1 cycle in RUN.
- A start pulse while in RUN is ignored.

## Structure
- Shared game package holds: NUM_SLOTS = 10, Y_EDGE = 120, state encoding (IDLE/RUN/OVER), and a popcount10 function.
- Sub-module `slot_picker`: combinational circular first-free search over c_en from the pointer. Outputs a 4-bit index and a `found` flag.
- Everything else (FSM, spawn counter, score/lives/level registers) lives in the top module.

## Test plan
- Reset, then start with SPAWN_CYCLES = 4 -> move_en = 1 after the start edge; c_en = 10'h001 after 4 cycles, 10'h003 after 8, 10'h007 after 12.
- Slot 1 active, hit[1] pulsed -> next edge: c_en[1] = 0, des[1] = 1 for one cycle, score = 1, lives unchanged.
- Slots 0 and 2 active, touch_edge[0] and touch_edge[2] asserted together -> lives 3 -> 1; both des bits pulse.
- hit[5] and touch_edge[5] together on active slot 5 -> score +1, lives unchanged. hit[7] on inactive slot 7 -> no change.
- All 10 slots active at the spawn point -> c_en stays 10'h3FF and the pointer is unchanged. Freeing slot 4 -> the next spawn picks slot 4.
- KILLS_PER_LEVEL = 2 with 8 hits -> flying_rate steps 1, 2, 3, 3. Three escapes -> OVER: game_over = 1, des = 10'h3FF, move_en = 0. start -> RUN with lives = 3, score = 0.
